// File: rtl/tmr_imu_spi_reader_pkg.sv
// ---------------------------------------------------------------------------
// tmr_imu_spi_reader_pkg
// Shared definitions for the triple-redundant IMU SPI reader and the TMR
// voter that consumes its samples.
//   spi_state_e  : reader FSM encoding (IDLE, SETUP, SHIFT, HOLD, GAP)
//   SPI_READ_BIT : value of command bit 7 for a register read
//   FRAME_BITS   : SCLK periods per frame (command byte + read byte)
//   SAMPLE_W     : width of one IMU sample
//   read_cmd()   : builds the read command byte from a 7-bit address
// ---------------------------------------------------------------------------
package tmr_imu_spi_reader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } spi_state_e;

    localparam logic SPI_READ_BIT = 1'b1;
    localparam int   FRAME_BITS   = 16;
    localparam int   SAMPLE_W     = 8;

    function automatic logic [7:0] read_cmd(input logic [6:0] addr);
        return {SPI_READ_BIT, addr};
    endfunction

endpackage

// File: rtl/tmr_imu_spi_reader_spi_rx_shift.sv
// ---------------------------------------------------------------------------
// tmr_imu_spi_reader_spi_rx_shift
// One MSB-first capture shift register for a single MISO line.
//   clk       in  system clock
//   reset     in  synchronous active-high reset (clears the register)
//   sample_en in  shift miso in on this clock edge
//   miso      in  serial data from the sensor
//   data      out last SAMPLE_W bits captured, first bit in the MSB
// ---------------------------------------------------------------------------
module tmr_imu_spi_reader_spi_rx_shift
    import tmr_imu_spi_reader_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_en,
    input  logic                miso,
    output logic [SAMPLE_W-1:0] data
);

    logic [SAMPLE_W-1:0] shift_q;
    logic [SAMPLE_W-1:0] shift_d;

    always_comb begin
        shift_d = shift_q;
        if (sample_en) begin
            shift_d = {shift_q[SAMPLE_W-2:0], miso};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign data = shift_q;

endmodule

// File: rtl/tmr_imu_spi_reader.sv
// ---------------------------------------------------------------------------
// tmr_imu_spi_reader
// SPI mode-0 master reading one signed byte from three redundant IMUs in
// lock-step: shared SCLK/MOSI, one chip select and one MISO per sensor.
// Frame = read command byte {1, REG_ADDR[6:0]} then one data byte, MSB first.
//   clk12MHz             in  system clock
//   reset                in  synchronous active-high reset
//   start                in  acquisition request
//   sclk, mosi           out shared SPI clock / data out
//   cs1_n, cs2_n, cs3_n  out per-sensor chip selects (identical)
//   miso1, miso2, miso3  in  per-sensor data in
//   imu1, imu2, imu3     out last completed samples (two's complement)
//   sample_valid         out one-cycle pulse when imu1..3 update
//   busy                 out acquisition in progress
//   dbg_state            out current FSM state
//
// Handshake: start is a single-cycle request that is accepted only when
// busy=0; a start seen while busy=1 is dropped, never queued. busy rises the
// cycle after acceptance and falls the cycle the inter-frame gap ends, which
// is also the first cycle a new start is accepted.
// ---------------------------------------------------------------------------
module tmr_imu_spi_reader
    import tmr_imu_spi_reader_pkg::*;
#(
    parameter int         CLK_DIV  = 6,
    parameter logic [7:0] REG_ADDR = 8'h3B
) (
    input  logic                       clk12MHz,
    input  logic                       reset,
    input  logic                       start,
    output logic                       sclk,
    output logic                       mosi,
    output logic                       cs1_n,
    output logic                       cs2_n,
    output logic                       cs3_n,
    input  logic                       miso1,
    input  logic                       miso2,
    input  logic                       miso3,
    output logic signed [SAMPLE_W-1:0] imu1,
    output logic signed [SAMPLE_W-1:0] imu2,
    output logic signed [SAMPLE_W-1:0] imu3,
    output logic                       sample_valid,
    output logic                       busy,
    output spi_state_e                 dbg_state
);

    localparam logic [7:0] CMD        = read_cmd(REG_ADDR[6:0]);
    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [3:0] BIT_LAST   = 4'(FRAME_BITS - 1);
    localparam logic [3:0] FIRST_DATA = 4'(FRAME_BITS - SAMPLE_W);

    spi_state_e          state_q, state_d;
    logic [7:0]          div_q, div_d;
    logic [3:0]          bit_q, bit_d;
    logic [7:0]          cmd_q, cmd_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic                cs_n_q, cs_n_d;
    logic                busy_q, busy_d;
    logic                valid_q, valid_d;
    logic [SAMPLE_W-1:0] imu1_q, imu1_d;
    logic [SAMPLE_W-1:0] imu2_q, imu2_d;
    logic [SAMPLE_W-1:0] imu3_q, imu3_d;

    logic                div_done;
    logic                capture_en;
    logic [SAMPLE_W-1:0] rx1, rx2, rx3;

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        cmd_d      = cmd_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        busy_d     = busy_q;
        valid_d    = 1'b0;
        imu1_d     = imu1_q;
        imu2_d     = imu2_q;
        imu3_d     = imu3_q;
        capture_en = 1'b0;
        div_done   = (div_q == DIV_LAST);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETUP;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    // Bit 7 goes out with CS; the remaining bits queue up
                    // behind it and zeros fill in once they are used up.
                    mosi_d  = CMD[7];
                    cmd_d   = {CMD[6:0], 1'b0};
                    div_d   = '0;
                    bit_d   = '0;
                end
            end

            // SETUP is the first low half-period; it shares the half-period
            // logic with SHIFT since sclk is low on entry.
            SETUP, SHIFT: begin
                if (!div_done) begin
                    div_d = div_q + 8'd1;
                end else begin
                    div_d = '0;
                    if (!sclk_q) begin
                        // Rising edge: sensors' data byte sits on edges 8..15.
                        sclk_d     = 1'b1;
                        capture_en = (bit_q >= FIRST_DATA);
                        state_d    = SHIFT;
                    end else begin
                        // Falling edge: advance MOSI and the bit count.
                        sclk_d = 1'b0;
                        mosi_d = cmd_q[7];
                        cmd_d  = {cmd_q[6:0], 1'b0};
                        if (bit_q == BIT_LAST) begin
                            state_d = HOLD;
                            bit_d   = '0;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end
                end
            end

            HOLD: begin
                if (!div_done) begin
                    div_d = div_q + 8'd1;
                end else begin
                    div_d   = '0;
                    cs_n_d  = 1'b1;
                    valid_d = 1'b1;
                    imu1_d  = rx1;
                    imu2_d  = rx2;
                    imu3_d  = rx3;
                    state_d = GAP;
                end
            end

            GAP: begin
                if (!div_done) begin
                    div_d = div_q + 8'd1;
                end else begin
                    div_d   = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk12MHz) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            cmd_q   <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            imu1_q  <= '0;
            imu2_q  <= '0;
            imu3_q  <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            cmd_q   <= cmd_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            imu1_q  <= imu1_d;
            imu2_q  <= imu2_d;
            imu3_q  <= imu3_d;
        end
    end

    tmr_imu_spi_reader_spi_rx_shift u_rx1 (
        .clk(clk12MHz), .reset(reset), .sample_en(capture_en), .miso(miso1), .data(rx1)
    );
    tmr_imu_spi_reader_spi_rx_shift u_rx2 (
        .clk(clk12MHz), .reset(reset), .sample_en(capture_en), .miso(miso2), .data(rx2)
    );
    tmr_imu_spi_reader_spi_rx_shift u_rx3 (
        .clk(clk12MHz), .reset(reset), .sample_en(capture_en), .miso(miso3), .data(rx3)
    );

    assign sclk         = sclk_q;
    assign mosi         = mosi_q;
    assign cs1_n        = cs_n_q;
    assign cs2_n        = cs_n_q;
    assign cs3_n        = cs_n_q;
    assign imu1         = imu1_q;
    assign imu2         = imu2_q;
    assign imu3         = imu3_q;
    assign sample_valid = valid_q;
    assign busy         = busy_q;
    assign dbg_state    = state_q;

endmodule
